// File: rtl/lc3b_types.sv
// Shared LC3B types: word, ALU op encoding and the mult/div sequencer state set.
package lc3b_types;

    localparam int WORD_W       = 16;
    localparam int MULDIV_ITERS = 16;

    typedef logic [WORD_W-1:0] lc3b_word;

    typedef enum logic [3:0] {
        alu_add,
        alu_and,
        alu_not,
        alu_pass,
        alu_sll,
        alu_srl,
        alu_sra,
        alu_mult,
        alu_div
    } lc3b_aluop;

    typedef enum logic [1:0] {
        md_idle,
        md_busy,
        md_done
    } lc3b_muldiv_state;

    function automatic logic muldiv_op_legal(input lc3b_aluop op);
        return (op == alu_mult) || (op == alu_div);
    endfunction

endpackage

// File: rtl/lc3b_muldiv_step.sv
// One mult/div iteration, purely combinational: shift-add for multiply,
// restoring trial-subtract for divide. part is the high half / remainder.
module lc3b_muldiv_step
    import lc3b_types::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] part_in,
    input  logic [WIDTH-1:0] shreg_in,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] part_out,
    output logic [WIDTH-1:0] shreg_out
);

    logic [WIDTH:0] addend;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    always_comb begin
        addend    = shreg_in[0] ? {1'b0, operand} : '0;
        sum       = {1'b0, part_in} + addend;
        trial     = {part_in, shreg_in[WIDTH-1]};
        diff      = trial - {1'b0, operand};
        part_out  = '0;
        shreg_out = '0;
        if (is_div) begin
            // Remainder stays below the divisor, so the borrow bit alone
            // decides whether the trial subtraction is kept.
            if (!diff[WIDTH]) begin
                part_out  = diff[WIDTH-1:0];
                shreg_out = {shreg_in[WIDTH-2:0], 1'b1};
            end else begin
                part_out  = trial[WIDTH-1:0];
                shreg_out = {shreg_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            part_out  = sum[WIDTH:1];
            shreg_out = {sum[0], shreg_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/lc3b_muldiv_seq.sv
// Multi-cycle unsigned multiply/divide sequencer; 16 iterations, done 16 cycles after accept.
// Start is only taken in idle (ready); abort returns to idle without done.
module lc3b_muldiv_seq
    import lc3b_types::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      start,
    input  lc3b_aluop aluop,
    input  lc3b_word  a,
    input  lc3b_word  b,
    input  logic      abort,
    output logic      ready,
    output logic      done,
    output lc3b_word  result_lo,
    output lc3b_word  result_hi,
    output logic      div_by_zero,
    output logic      illegal_op
);

    lc3b_muldiv_state   state;
    logic [CNT_W-1:0]   count;
    logic               op_div;
    logic               dbz_pend;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   part;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   part_nx;
    logic [WIDTH-1:0]   shreg_nx;
    logic               accept;
    logic               last_iter;

    lc3b_muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div    (op_div),
        .part_in   (part),
        .shreg_in  (shreg),
        .operand   (operand),
        .part_out  (part_nx),
        .shreg_out (shreg_nx)
    );

    assign ready     = (state == md_idle);
    assign done      = (state == md_done);
    assign accept    = ready && start && muldiv_op_legal(aluop);
    assign last_iter = (count == CNT_W'(MULDIV_ITERS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= md_idle;
        end else begin
            case (state)
                md_idle: if (accept) state <= md_busy;
                md_busy: begin
                    if (abort)          state <= md_idle;
                    else if (last_iter) state <= md_done;
                end
                md_done: state <= md_idle;
                default: state <= md_idle;
            endcase
        end
    end

    // Multiply keeps the multiplier in shreg and adds a; divide shifts the
    // dividend out of shreg and subtracts b. Either way {part, shreg} is the result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            op_div   <= 1'b0;
            dbz_pend <= 1'b0;
            operand  <= '0;
            part     <= '0;
            shreg    <= '0;
        end else if (accept) begin
            count    <= '0;
            op_div   <= (aluop == alu_div);
            dbz_pend <= (aluop == alu_div) && (b == '0);
            operand  <= (aluop == alu_div) ? b : a;
            shreg    <= (aluop == alu_div) ? a : b;
            part     <= '0;
        end else if (state == md_busy && !abort) begin
            count <= count + 1'b1;
            part  <= part_nx;
            shreg <= shreg_nx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
        end else if (state == md_busy && !abort && last_iter) begin
            result_lo   <= shreg_nx;
            result_hi   <= part_nx;
            div_by_zero <= dbz_pend;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= ready && start && !muldiv_op_legal(aluop);
        end
    end

endmodule

// File: tb/tb_lc3b_muldiv_seq.sv
// Bench for lc3b_muldiv_seq: directed cases with literal results, then random traffic
// against a cycle-level behavioural model using plain * / % arithmetic.
module tb_lc3b_muldiv_seq;
    import lc3b_types::*;

    logic      clk     = 1'b0;
    logic      reset_n = 1'b0;
    logic      start   = 1'b0;
    logic      abort   = 1'b0;
    lc3b_aluop aluop   = alu_add;
    lc3b_word  a       = '0;
    lc3b_word  b       = '0;
    logic      ready, done, div_by_zero, illegal_op;
    lc3b_word  result_lo, result_hi;

    int n_cmp  = 0;
    int n_bad  = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    lc3b_muldiv_seq #(.WIDTH(16), .CNT_W(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .aluop       (aluop),
        .a           (a),
        .b           (b),
        .abort       (abort),
        .ready       (ready),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void ref_op(input lc3b_aluop op, input lc3b_word x, input lc3b_word y,
                                   output lc3b_word lo, output lc3b_word hi, output logic z);
        logic [31:0] p;
        if (op == alu_mult) begin
            p  = 32'(x) * 32'(y);
            lo = p[15:0];
            hi = p[31:16];
            z  = 1'b0;
        end else if (y == 16'h0) begin
            lo = 16'hFFFF;
            hi = x;
            z  = 1'b1;
        end else begin
            lo = x / y;
            hi = x % y;
            z  = 1'b0;
        end
    endfunction

    // Model: m_left = cycles of non-ready remaining; 17 after accept, 1 = done cycle.
    int       m_left = 0;
    lc3b_word m_lo = '0, m_hi = '0, p_lo = '0, p_hi = '0;
    logic     m_dbz = 1'b0, p_dbz = 1'b0, m_ill = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_left = 0;
            m_lo   = '0;
            m_hi   = '0;
            m_dbz  = 1'b0;
            m_ill  = 1'b0;
        end else begin
            m_ill = 1'b0;
            if (m_left > 0) begin
                if (abort) begin
                    m_left = 0;
                end else begin
                    m_left--;
                    if (m_left == 1) begin
                        m_lo  = p_lo;
                        m_hi  = p_hi;
                        m_dbz = p_dbz;
                    end
                end
            end else if (start) begin
                if (aluop == alu_mult || aluop == alu_div) begin
                    ref_op(aluop, a, b, p_lo, p_hi, p_dbz);
                    m_left = 17;
                end else begin
                    m_ill = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && reset_n) begin
            chk("ready", 32'(ready), 32'(m_left == 0));
            chk("done", 32'(done), 32'(m_left == 1));
            chk("result_lo", 32'(result_lo), 32'(m_lo));
            chk("result_hi", 32'(result_hi), 32'(m_hi));
            chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
            chk("illegal_op", 32'(illegal_op), 32'(m_ill));
        end
    end

    // Issues one op; hold keeps start asserted with scrambled operands while busy.
    task automatic run_op(input lc3b_aluop op, input lc3b_word x, input lc3b_word y, input bit hold,
                          output int lat, output lc3b_word lo, output lc3b_word hi, output logic z);
        lat = -1;
        lo  = '0;
        hi  = '0;
        z   = 1'b0;
        @(posedge clk); #2;
        start = 1'b1;
        aluop = op;
        a     = x;
        b     = y;
        @(posedge clk); #2;
        if (hold) begin
            a     = ~x;
            b     = y + 16'd3;
            aluop = (op == alu_mult) ? alu_div : alu_mult;
        end else begin
            start = 1'b0;
        end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                lo  = result_lo;
                hi  = result_hi;
                z   = div_by_zero;
                break;
            end
            @(posedge clk);
        end
        start = 1'b0;
        if (lat < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: no done within 40 cycles, required 16");
        end
    endtask

    int       lat;
    lc3b_word lo, hi;
    logic     z;
    int       n_done;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_lo", 32'(result_lo), 32'd0);
        chk("rst_hi", 32'(result_hi), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        chk("rst_ill", 32'(illegal_op), 32'd0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        chk_en  = 1'b1;

        run_op(alu_mult, 16'h0003, 16'h0005, 1'b0, lat, lo, hi, z);
        chk("mul3x5_lat", 32'(lat), 32'd16);
        chk("mul3x5", {hi, lo}, 32'h0000_000F);
        chk("mul3x5_dbz", 32'(z), 32'd0);

        run_op(alu_mult, 16'hFFFF, 16'hFFFF, 1'b0, lat, lo, hi, z);
        chk("mulFFFF", {hi, lo}, 32'hFFFE_0001);
        run_op(alu_div, 16'd100, 16'd7, 1'b0, lat, lo, hi, z);
        chk("div100_7", {hi, lo}, 32'h0002_000E);

        run_op(alu_div, 16'h1234, 16'h0000, 1'b0, lat, lo, hi, z);
        chk("div0_lat", 32'(lat), 32'd16);
        chk("div0", {hi, lo}, 32'h1234_FFFF);
        chk("div0_dbz", 32'(z), 32'd1);
        run_op(alu_div, 16'h0010, 16'h0004, 1'b0, lat, lo, hi, z);
        chk("div16_4", {hi, lo}, 32'h0000_0004);
        chk("div16_4_dbz", 32'(z), 32'd0);

        @(posedge clk); #2;
        start = 1'b1;
        aluop = alu_add;
        a     = 16'h1111;
        b     = 16'h2222;
        @(posedge clk); #2;
        start = 1'b0;
        @(negedge clk);
        chk("ill_pulse", 32'(illegal_op), 32'd1);
        chk("ill_ready", 32'(ready), 32'd1);
        chk("ill_lo_kept", 32'(result_lo), 32'h0004);
        @(negedge clk);
        chk("ill_pulse_end", 32'(illegal_op), 32'd0);

        run_op(alu_mult, 16'h0012, 16'h0034, 1'b1, lat, lo, hi, z);
        chk("held_start", {hi, lo}, 32'h0000_03A8);

        @(posedge clk); #2;
        start = 1'b1;
        aluop = alu_mult;
        a     = 16'h00FF;
        b     = 16'h0101;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2 abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_lo_kept", 32'(result_lo), 32'h03A8);
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort_no_done", 32'(n_done), 32'd0);
        run_op(alu_mult, 16'd2, 16'd2, 1'b0, lat, lo, hi, z);
        chk("mul2x2", {hi, lo}, 32'h0000_0004);

        @(posedge clk); #2;
        start = 1'b1;
        aluop = alu_mult;
        a     = 16'd7;
        b     = 16'd9;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_ready", 32'(ready), 32'd1);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_res", {result_hi, result_lo}, 32'd0);
        chk("arst_dbz", 32'(div_by_zero), 32'd0);
        @(posedge clk);
        @(posedge clk); #2;
        reset_n = 1'b1;
        run_op(alu_mult, 16'd7, 16'd9, 1'b0, lat, lo, hi, z);
        chk("post_rst_mul", {hi, lo}, 32'h0000_003F);
        chk("post_rst_lat", 32'(lat), 32'd16);

        for (int i = 0; i < 600; i++) begin
            int r;
            @(posedge clk); #2;
            r     = int'($urandom_range(0, 9));
            start = ($urandom_range(0, 3) == 0);
            if (r < 4)      aluop = alu_mult;
            else if (r < 8) aluop = alu_div;
            else            aluop = lc3b_aluop'($urandom_range(0, 6));
            a     = lc3b_word'($urandom);
            b     = ($urandom_range(0, 4) == 0) ? 16'h0 :
                    ($urandom_range(0, 1) == 0) ? lc3b_word'($urandom_range(1, 20)) : lc3b_word'($urandom);
            abort = ($urandom_range(0, 24) == 0);
        end
        @(posedge clk); #2;
        start = 1'b0;
        abort = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lc3b_muldiv_seq.md
Name: lc3b_muldiv_seq

Overview:
Multi-cycle unsigned multiply/divide sequencer for the LC3X extension. It replaces the single-cycle a*b and a/b ALU paths with a 16-iteration shift-add / restoring-divide engine, using a start/ready/done handshake. The CPU control FSM issues the op, stalls until done, then muxes result_lo into the ALU output path.

Parameters:
WIDTH, 16, operand/result width; must equal lc3b_word width.
CNT_W, 4, iteration counter width; equals clog2(WIDTH).

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when ready=1
aluop  input  lc3b_aluop  alu_mult or alu_div; any other value is illegal
a  input  lc3b_word  multiplicand / dividend
b  input  lc3b_word  multiplier / divisor
abort  input  1  synchronous cancel of an in-flight op
ready  output  1  high in IDLE only
done  output  1  one-cycle pulse; results valid
result_lo  output  lc3b_word  mult: product[15:0]; div: quotient
result_hi  output  lc3b_word  mult: product[31:16]; div: remainder
div_by_zero  output  1  set with done when div and b==0
illegal_op  output  1  one-cycle pulse when start rejected for bad aluop

Behaviour:
- Reset (async, reset_n=0): state=IDLE, counter=0, all internal regs=0; ready=1, done=0, result_lo=0, result_hi=0, div_by_zero=0, illegal_op=0. Takes effect mid-operation: the op is lost and no done is issued.
- States: IDLE, BUSY, DONE.
- IDLE: ready=1. On start && aluop in {alu_mult, alu_div}: latch a, b, op. Set count=0 and go to BUSY (edge E0). On start with another aluop: stay in IDLE, pulse illegal_op for the next cycle, latch nothing. No start: hold.
- BUSY: ready=0. One iteration per edge, count++. The edge with count==15 goes to DONE. Iterations occur at E1..E16.
- DONE: done=1 for exactly one cycle, the cycle after E16, i.e. 16 cycles after the accepting edge. Next edge goes to IDLE. ready goes low at E0 and high again after E17.
- result_lo, result_hi and div_by_zero update only on entry to DONE. They hold until the next DONE or reset and are not cleared by a new start.
- Mult algorithm: unsigned shift-add over a 32-bit accumulator. result = {hi, lo} = a*b mod 2^32.
- Div algorithm: unsigned restoring divide with a 17-bit partial remainder.
- Div, b==0: no trap. Quotient=16'hFFFF, remainder=a, div_by_zero=1. Still 16 cycles, so latency is constant.
- div_by_zero=0 for every mult and every div with b!=0.
- start during BUSY or DONE: ignored, with no effect on the latched operands.
- abort: honoured in BUSY or DONE. Next edge goes to IDLE; done is not asserted (abort in DONE suppresses nothing already emitted); results are unchanged. abort in IDLE has no effect. abort and start together in IDLE: start wins.
- done and ready are never high in the same cycle.

Decomposition:
- Shared lc3b_types package:
  - lc3b_aluop enum (existing alu_mult, alu_div).
  - lc3b_word.
  - New enum lc3b_muldiv_state {md_idle, md_busy, md_done}.
  - Constant MULDIV_ITERS = 16.
- One natural sub-module, lc3b_muldiv_step. It is a combinational single-iteration datapath: given op, accumulator/remainder and operand, it produces the next accumulator/remainder and the shifted quotient/multiplier. The sequencer keeps the FSM, counter and registers.

Test Plan:
- Mult 0x0003 x 0x0005, start for 1 cycle → done exactly 16 cycles after the accepting edge; lo=0x000F, hi=0x0000, div_by_zero=0; ready low for 17 cycles.
- Mult 0xFFFF x 0xFFFF → lo=0x0001, hi=0xFFFE. Then div 100/7 issued the cycle ready returns → lo=0x000E, hi=0x0002.
- Div 0x1234/0x0000 → lo=0xFFFF, hi=0x1234, div_by_zero=1 with done, same 16-cycle latency. Following div 0x0010/0x0004 → lo=0x0004, hi=0, div_by_zero=0.
- start with aluop=alu_add → illegal_op pulses 1 cycle, ready stays 1, no done, results unchanged. start held high during BUSY with new operands → ignored, original result returned.
- abort at iteration 8 of a mult → IDLE next edge, no done, prior results retained. New mult 2x2 then yields lo=0x0004.
- reset_n low asynchronously mid-BUSY (between edges) → outputs reset immediately, no done. After release, a normal op completes correctly.
